// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between RegisterFile read ports and the HI/LO multiply/divide unit.
// The master drives operands and requests; the slave returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [2:0]       Op;
    logic             Start;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output BusA, BusB, Op, Start,
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  BusA, BusB, Op, Start,
        output Busy, Done, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one bit per cycle,
// with sign correction applied in a final FIX cycle before HI/LO are written.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  ResetL,
    mult_div_unit_if.slave        bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;         // product upper half / partial remainder
    logic [WIDTH-1:0]   mq_q, mq_d;           // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               busy;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // State register and all datapath flops
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            dvd_raw_q <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            dvd_raw_q <= dvd_raw_d;
            is_div_q  <= is_div_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign accept = (state_q == S_IDLE) && bus.Start && !bus.Op[2];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath: operand capture, one iteration per RUN cycle, result fix-up
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        dvd_raw_d = dvd_raw_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        a_neg   = !bus.Op[0] && bus.BusA[WIDTH-1];
        b_neg   = !bus.Op[0] && bus.BusB[WIDTH-1];
        a_mag   = cond_neg(bus.BusA, a_neg);
        b_mag   = cond_neg(bus.BusB, b_neg);
        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_q, mq_q[WIDTH-1]};
        prod    = cond_neg2({acc_q, mq_q}, neg_lo_q);

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            cnt_d     = '0;
                            acc_d     = '0;
                            mq_d      = a_mag;
                            opnd_d    = b_mag;
                            dvd_raw_d = bus.BusA;
                            is_div_d  = bus.Op[1];
                            neg_lo_d  = a_neg ^ b_neg;
                            neg_hi_d  = a_neg;
                            div0_d    = (bus.BusB == '0);
                        end
                        OP_MTHI: hi_d = bus.BusA;
                        OP_MTLO: lo_d = bus.BusA;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    // Restoring step: keep the subtraction only when it does not underflow
                    if (rem_sh >= {1'b0, opnd_q}) begin
                        acc_d = WIDTH'(rem_sh - {1'b0, opnd_q});
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    if (div0_q) begin
                        lo_d = '1;
                        hi_d = dvd_raw_q;
                    end else begin
                        lo_d = cond_neg(mq_q, neg_lo_q);
                        hi_d = cond_neg(acc_q, neg_hi_q);
                    end
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    assign bus.Busy = busy;
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results, divide corner cases,
// MTHI/MTLO, requests while busy, and asynchronous reset mid-operation.
module tb_mult_div_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   done_cnt;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk    (clk),
        .ResetL (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Op    = op;
        bus.BusA  = a;
        bus.BusB  = b;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        bus.Op    = 3'b110;
    endtask

    // Counts edges after the current point until Busy falls (bounded)
    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start_op(op, a, b);
        chk({tag, "_busy"}, 32'(bus.Busy), 32'd1);
        wait_idle(n);
        chk({tag, "_latency"}, 32'(n), 32'd33);
        chk({tag, "_done"}, 32'(bus.Done), 32'd1);
        chk({tag, "_hi"}, bus.Hi, exp_hi);
        chk({tag, "_lo"}, bus.Lo, exp_lo);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.BusA  = '0;
        bus.BusB  = '0;
        bus.Op    = 3'b110;
        bus.Start = 1'b0;

        step();
        step();
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_hi", bus.Hi, 32'h0);
        chk("rst_lo", bus.Lo, 32'h0);
        rst_n = 1'b1;
        step();

        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        step();
        chk("multu_done_pulse", 32'(bus.Done), 32'd0);

        run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        // Next request issued in the Done cycle is accepted on the edge that ends it
        run_op("mult_minmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negdivisor", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_small", 3'b011, 32'd7, 32'd2, 32'h0000_0001, 32'h0000_0003);
        run_op("divu_zero", 3'b011, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 3'b010, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        step();

        start_op(3'b101, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_lo", bus.Lo, 32'hCAFE_F00D);
        chk("mtlo_done", 32'(bus.Done), 32'd0);
        chk("mtlo_busy", 32'(bus.Busy), 32'd0);
        start_op(3'b100, 32'h1111_2222, 32'd0);
        chk("mthi_hi", bus.Hi, 32'h1111_2222);
        chk("mthi_lo_kept", bus.Lo, 32'hCAFE_F00D);
        start_op(3'b110, 32'h5555_5555, 32'h5555_5555);
        chk("noop_hi", bus.Hi, 32'h1111_2222);
        chk("noop_busy", 32'(bus.Busy), 32'd0);

        start_op(3'b011, 32'd100, 32'd7);
        step();
        step();
        step();
        start_op(3'b100, 32'hDEAD_BEEF, 32'd0);
        chk("busy_mthi_ignored", bus.Hi, 32'h1111_2222);
        start_op(3'b000, 32'd9, 32'd9);
        bus.BusA = 32'hFFFF_FFFF;
        bus.BusB = 32'd1;
        chk("busy_lo_held", bus.Lo, 32'hCAFE_F00D);
        wait_idle(cyc);
        chk("divu_busy_latency", 32'(cyc + 5), 32'd33);
        chk("divu_busy_done", 32'(bus.Done), 32'd1);
        chk("divu_busy_hi", bus.Hi, 32'd2);
        chk("divu_busy_lo", bus.Lo, 32'd14);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.Done === 1'b1) done_cnt++;
        end
        chk("single_done", 32'(done_cnt), 32'd0);
        chk("no_queued_busy", 32'(bus.Busy), 32'd0);

        start_op(3'b001, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_busy", 32'(bus.Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.Busy), 32'd0);
        chk("midrst_done", 32'(bus.Done), 32'd0);
        chk("midrst_hi", bus.Hi, 32'h0);
        chk("midrst_lo", bus.Lo, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(bus.Busy), 32'd0);
        run_op("multu_after_rst", 3'b001, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
        step();
        chk("final_done_low", 32'(bus.Done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
